silife_cell_grid: RTL



---
 rtl/silife_cell_grid_if.sv | 26 ++
 rtl/silife_cell_grid.sv | 112 +++++++++++
 2 files changed

// File: rtl/silife_cell_grid_if.sv
// Host-side bus of the SiLife cell grid: row access strobes, step request and status.
interface silife_cell_grid_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8
);
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [ROW_W-1:0] row_select;
    logic [WIDTH-1:0] set_cells;
    logic [WIDTH-1:0] clear_cells;
    logic             step;
    logic [WIDTH-1:0] cells;
    logic [15:0]      generation;
    logic             stable;
    logic             step_pending;

    modport master (
        output row_select, set_cells, clear_cells, step,
        input  cells, generation, stable, step_pending
    );

    modport slave (
        input  row_select, set_cells, clear_cells, step,
        output cells, generation, stable, step_pending
    );
endinterface

// File: rtl/silife_cell_grid.sv
// SiLife cell grid: WIDTH x HEIGHT cell registers evolving under B3/S23,
// with host row writes that always win the edge and defer a colliding step.
module silife_cell_grid #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8,
    parameter int unsigned WRAP   = 1
) (
    input  logic              clk,
    input  logic              reset,
    silife_cell_grid_if.slave bus
);
    localparam int unsigned CELLS = WIDTH * HEIGHT;

    logic [HEIGHT-1:0][WIDTH-1:0] r_grid;
    logic [15:0]                  r_generation;
    logic                         r_stable;
    logic                         r_step_pending;

    logic [CELLS-1:0]             w_flat;
    logic [HEIGHT-1:0]            w_row_hit;
    logic [HEIGHT-1:0][WIDTH-1:0] w_acc;
    logic [HEIGHT-1:0][WIDTH-1:0] w_wr_grid;
    logic [HEIGHT-1:0][WIDTH-1:0] w_next;
    logic [WIDTH-1:0]             w_cur_row;
    logic [WIDTH-1:0]             w_new_row;
    logic                         w_wr_act;
    logic                         w_wr_change;
    logic                         w_do_step;

    // Neighbour lookup: toroidal fold when wrapping, dead border otherwise.
    function automatic logic nb(input logic [CELLS-1:0] flat, input int r, input int c);
        int rr;
        int cc;
        rr = r;
        cc = c;
        if (WRAP != 0) begin
            rr = (r + int'(HEIGHT)) % int'(HEIGHT);
            cc = (c + int'(WIDTH)) % int'(WIDTH);
        end else if (r < 0 || r >= int'(HEIGHT) || c < 0 || c >= int'(WIDTH)) begin
            return 1'b0;
        end
        return |(flat & (CELLS'(1) << 32'(rr * int'(WIDTH) + cc)));
    endfunction

    assign w_flat    = r_grid;
    assign w_wr_act  = |(bus.set_cells | bus.clear_cells);
    assign w_do_step = bus.step | r_step_pending;

    // Row read mux; an out-of-range row_select hits nothing and reads 0.
    for (genvar gr = 0; gr < int'(HEIGHT); gr++) begin : g_row
        assign w_row_hit[gr] = (32'(bus.row_select) == 32'(gr));
        if (gr == 0) begin : g_first
            assign w_acc[gr] = w_row_hit[gr] ? r_grid[gr] : '0;
        end else begin : g_rest
            assign w_acc[gr] = w_acc[gr-1] | (w_row_hit[gr] ? r_grid[gr] : '0);
        end
        assign w_wr_grid[gr] = w_row_hit[gr] ? w_new_row : r_grid[gr];
    end

    assign w_cur_row   = w_acc[HEIGHT-1];
    assign w_new_row   = (w_cur_row & ~bus.clear_cells) | bus.set_cells;
    assign w_wr_change = (w_wr_grid != r_grid);

    // Next generation, one rule evaluation per cell.
    for (genvar gr = 0; gr < int'(HEIGHT); gr++) begin : g_life_r
        for (genvar gc = 0; gc < int'(WIDTH); gc++) begin : g_life_c
            logic [3:0] w_cnt;

            // Count the eight neighbours of this cell.
            always_comb begin
                w_cnt = '0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            w_cnt = w_cnt + 4'(nb(w_flat, gr + dr, gc + dc));
                        end
                    end
                end
            end

            assign w_next[gr][gc] = (w_cnt == 4'd3) || (r_grid[gr][gc] && (w_cnt == 4'd2));
        end
    end

    // Writes take the edge and park any step; otherwise a requested step evolves the grid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grid         <= '0;
            r_generation   <= '0;
            r_stable       <= 1'b0;
            r_step_pending <= 1'b0;
        end else if (w_wr_act) begin
            r_grid <= w_wr_grid;
            if (w_do_step) begin
                r_step_pending <= 1'b1;
            end
            if (w_wr_change) begin
                r_stable <= 1'b0;
            end
        end else if (w_do_step) begin
            r_grid         <= w_next;
            r_generation   <= r_generation + 16'd1;
            r_stable       <= (w_next == r_grid);
            r_step_pending <= 1'b0;
        end
    end

    assign bus.cells        = w_cur_row;
    assign bus.generation   = r_generation;
    assign bus.stable       = r_stable;
    assign bus.step_pending = r_step_pending;
endmodule
